// File: rtl/pow_sched_ctrl.sv
// Square-and-multiply sequencer for a0 = a1^a2 mod a3.
// Holds the operand and result registers, walks the exponent from the top bit
// down, and drives a shared modular multiplier one operation at a time.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for the first start after reset
// S_SCAN     | skipping leading exponent zeros, one bit per cycle
// S_MUL_WAIT | r*base (or 1*base) in flight, waiting for mm_done
// S_SQR_WAIT | r*r in flight, waiting for mm_done
// S_DONE     | result and err presented, done held until the next start
module pow_sched_ctrl #(
   parameter int NBITS = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NBITS-1:0] a1,
   input  logic [NBITS-1:0] a2,
   input  logic [NBITS-1:0] a3,
   output logic [NBITS-1:0] a0,
   output logic             done,
   output logic             err,
   output logic             busy,
   output logic             mm_start,
   output logic [NBITS-1:0] mm_a,
   output logic [NBITS-1:0] mm_b,
   output logic [NBITS-1:0] mm_n,
   input  logic             mm_done,
   input  logic [NBITS-1:0] mm_result
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_MUL_WAIT,
      S_SQR_WAIT,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NBITS - 1);
   localparam logic [NBITS-1:0] ONE     = NBITS'(1);

   state_t           state, state_d;
   logic [NBITS-1:0] base, base_d;
   logic [NBITS-1:0] expo, expo_d;
   logic [NBITS-1:0] modulus, modulus_d;
   logic [NBITS-1:0] r, r_d;
   logic [IDX_W-1:0] idx, idx_d;
   logic [NBITS-1:0] a0_d;
   logic             done_d;
   logic             err_d;
   logic             busy_d;
   logic             mm_start_d;
   logic [NBITS-1:0] mm_a_d;
   logic [NBITS-1:0] mm_b_d;
   logic             op_back;
   logic             exp_bit;
   logic             idx_zero;

   // The multiplier always sees the modulus latched at job start.
   assign mm_n = modulus;

   // A completion in the same cycle as our own launch pulse cannot belong to
   // this op (latency is at least one cycle), so it is discarded.
   assign op_back  = mm_done & ~mm_start;
   assign exp_bit  = expo[idx];
   assign idx_zero = (idx == '0);

   // Next-state and register-update decisions for the whole sequencer.
   always_comb begin
      state_d    = state;
      base_d     = base;
      expo_d     = expo;
      modulus_d  = modulus;
      r_d        = r;
      idx_d      = idx;
      a0_d       = a0;
      done_d     = done;
      err_d      = err;
      busy_d     = busy;
      mm_start_d = 1'b0;
      mm_a_d     = mm_a;
      mm_b_d     = mm_b;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               base_d    = a1;
               expo_d    = a2;
               modulus_d = a3;
               idx_d     = IDX_TOP;
               r_d       = '0;
               done_d    = 1'b0;
               err_d     = 1'b0;
               busy_d    = 1'b1;
               state_d   = S_SCAN;
            end
         end

         S_SCAN: begin
            if (modulus == '0) begin
               a0_d    = '0;
               err_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else if (exp_bit) begin
               // First set bit: r = 1*base goes through the multiplier so the
               // base is reduced exactly like every later product.
               mm_start_d = 1'b1;
               mm_a_d     = ONE;
               mm_b_d     = base;
               state_d    = S_MUL_WAIT;
            end else if (!idx_zero) begin
               idx_d = idx - 1'b1;
            end else begin
               a0_d    = (modulus == ONE) ? '0 : ONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end
         end

         S_MUL_WAIT: begin
            if (op_back) begin
               r_d = mm_result;
               if (idx_zero) begin
                  a0_d    = mm_result;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_DONE;
               end else begin
                  idx_d      = idx - 1'b1;
                  mm_start_d = 1'b1;
                  mm_a_d     = mm_result;
                  mm_b_d     = mm_result;
                  state_d    = S_SQR_WAIT;
               end
            end
         end

         S_SQR_WAIT: begin
            if (op_back) begin
               r_d = mm_result;
               if (exp_bit) begin
                  mm_start_d = 1'b1;
                  mm_a_d     = mm_result;
                  mm_b_d     = base;
                  state_d    = S_MUL_WAIT;
               end else if (idx_zero) begin
                  a0_d    = mm_result;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_DONE;
               end else begin
                  idx_d      = idx - 1'b1;
                  mm_start_d = 1'b1;
                  mm_a_d     = mm_result;
                  mm_b_d     = mm_result;
                  state_d    = S_SQR_WAIT;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, operand, result and multiplier-interface registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         base     <= '0;
         expo     <= '0;
         modulus  <= '0;
         r        <= '0;
         idx      <= IDX_TOP;
         a0       <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b0;
         mm_start <= 1'b0;
         mm_a     <= '0;
         mm_b     <= '0;
      end else begin
         state    <= state_d;
         base     <= base_d;
         expo     <= expo_d;
         modulus  <= modulus_d;
         r        <= r_d;
         idx      <= idx_d;
         a0       <= a0_d;
         done     <= done_d;
         err      <= err_d;
         busy     <= busy_d;
         mm_start <= mm_start_d;
         mm_a     <= mm_a_d;
         mm_b     <= mm_b_d;
      end
   end

endmodule

// File: tb/tb_pow_sched_ctrl.sv
// Bench for pow_sched_ctrl: behavioural multiplier with fixed latency,
// job results and (for the small job) the expected op stream are queued at
// start and compared as the DUT produces them.
module tb_pow_sched_ctrl;

   localparam int NBITS = 256;
   localparam int IDX_W = 8;
   localparam int LAT   = 4;
   localparam int LIMIT = 20000;

   localparam logic [NBITS-1:0] FA1 = 256'hD41B_7C39_0A5E_8F21_6B3D_94C7_E205_1A8F_3C6D_70B9_58E4_A12F_9D07_4B6E_C8A3_2E31;
   localparam logic [NBITS-1:0] FA2 = 256'h5972_A0C4_1E8B_3F65_D217_8A49_06BC_E3F1_7D28_94A6_C05B_1E73_8F4D_2A96_B0E5_228D;
   localparam logic [NBITS-1:0] FA3 = 256'hE071_5C2A_9B84_F36D_1E07_A5C9_4D82_6B3F_F019_2C7E_85A4_3D6B_9E10_C7F2_5A48_73E1;
   localparam logic [NBITS-1:0] FB1 = 256'hC60B_3E95_71D4_0A8C_F267_5B19_E4A3_8D0F_2C76_B951_0E8A_D34C_7F12_6A9E_45D3_B71A;

   typedef struct {
      logic [NBITS-1:0] a0;
      logic             err;
   } job_t;

   typedef struct {
      logic [NBITS-1:0] a;
      logic [NBITS-1:0] b;
   } op_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [NBITS-1:0] a1, a2, a3;
   logic [NBITS-1:0] a0;
   logic             done, err, busy;
   logic             mm_start;
   logic [NBITS-1:0] mm_a, mm_b, mm_n;
   logic             mm_done;
   logic [NBITS-1:0] mm_result;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int mm_cnt = 0;
   int n_ops = 0;
   int first_op_cyc = -1;
   int last_done_cyc = -1;
   int s_cyc = 0;
   int exp_ops = 0;
   int exp_scan = 0;
   bit op_chk = 0;
   bit spur_req = 0;
   logic [NBITS-1:0] cap_a, cap_b, cap_n, cur_mod;

   job_t exp_q[$];
   op_t  op_q[$];

   pow_sched_ctrl #(.NBITS(NBITS), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a1        (a1),
      .a2        (a2),
      .a3        (a3),
      .a0        (a0),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .mm_start  (mm_start),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_n      (mm_n),
      .mm_done   (mm_done),
      .mm_result (mm_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [NBITS-1:0] got, input logic [NBITS-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [NBITS-1:0] mulmod(input logic [NBITS-1:0] x, input logic [NBITS-1:0] y,
                                               input logic [NBITS-1:0] m);
      logic [2*NBITS-1:0] p;
      if (m == '0) return '0;
      p = {{NBITS{1'b0}}, x} * {{NBITS{1'b0}}, y};
      p = p % {{NBITS{1'b0}}, m};
      return p[NBITS-1:0];
   endfunction

   // Right-to-left binary exponentiation as an independent reference.
   function automatic logic [NBITS-1:0] mod_exp(input logic [NBITS-1:0] b, input logic [NBITS-1:0] e,
                                               input logic [NBITS-1:0] m);
      logic [NBITS-1:0] res, sq;
      if (m == '0) return '0;
      res = (m == NBITS'(1)) ? '0 : NBITS'(1);
      sq  = mulmod(b, NBITS'(1), m);
      for (int i = 0; i < NBITS; i++) begin
         if (e[i]) res = mulmod(res, sq, m);
         sq = mulmod(sq, sq, m);
      end
      return res;
   endfunction

   // One clock cycle: wait for the falling edge, then act as the multiplier.
   task automatic tick();
      op_t o;
      @(negedge clk);
      cyc++;
      mm_done = 1'b0;
      if (!rst_n) begin
         mm_cnt   = 0;
         spur_req = 0;
      end else begin
         if (spur_req) begin
            mm_done   = 1'b1;
            mm_result = {4{64'hBAD0_BAD0_BAD0_BAD0}};
            spur_req  = 0;
         end
         if (mm_cnt > 0) begin
            mm_cnt--;
            if (mm_cnt == 0) begin
               check_val("mm_a_stable", mm_a, cap_a);
               check_val("mm_b_stable", mm_b, cap_b);
               mm_done       = 1'b1;
               mm_result     = mulmod(cap_a, cap_b, cap_n);
               last_done_cyc = cyc;
            end
         end
         if (mm_start) begin
            check_val("one_outstanding", mm_cnt, 0);
            check_val("mm_n", mm_n, cur_mod);
            cap_a  = mm_a;
            cap_b  = mm_b;
            cap_n  = mm_n;
            mm_cnt = LAT;
            n_ops++;
            if (n_ops == 1) first_op_cyc = cyc;
            if (op_chk) begin
               if (op_q.size() == 0) begin
                  check_val("op_extra", 1, 0);
               end else begin
                  o = op_q.pop_front();
                  check_val("op_a", mm_a, o.a);
                  check_val("op_b", mm_b, o.b);
               end
            end
         end
      end
   endtask

   task automatic start_job(input logic [NBITS-1:0] x1, input logic [NBITS-1:0] x2, input logic [NBITS-1:0] x3);
      job_t j;
      int   msb;
      int   pc;
      j.a0  = mod_exp(x1, x2, x3);
      j.err = (x3 == '0);
      exp_q.push_back(j);
      msb = -1;
      pc  = 0;
      for (int i = 0; i < NBITS; i++) begin
         if (x2[i]) begin
            msb = i;
            pc++;
         end
      end
      exp_ops       = (x3 == '0 || msb < 0) ? 0 : msb + pc;
      exp_scan      = (msb < 0) ? 0 : NBITS - msb;
      cur_mod       = x3;
      n_ops         = 0;
      first_op_cyc  = -1;
      last_done_cyc = -1;
      a1    = x1;
      a2    = x2;
      a3    = x3;
      start = 1'b1;
      s_cyc = cyc;
      tick();
      start = 1'b0;
      check_val("done_drop", done, 0);
      check_val("busy_set", busy, 1);
   endtask

   task automatic wait_done(input string name, input int inj_at, input int spur_at);
      int   waited;
      int   want_lat;
      job_t j;
      waited = 0;
      while (done !== 1'b1 && waited < LIMIT) begin
         if (waited == inj_at) begin
            start = 1'b1;
            a1    = '1;
            a2    = '1;
            a3    = NBITS'(3);
         end else begin
            start = 1'b0;
         end
         if (waited == spur_at) spur_req = 1;
         tick();
         waited++;
      end
      start = 1'b0;
      j = exp_q.pop_front();
      if (done !== 1'b1) begin
         check_val({name, "_timeout"}, 0, 1);
         return;
      end
      check_val({name, "_a0"}, a0, j.a0);
      check_val({name, "_err"}, err, j.err);
      check_val({name, "_busy_clr"}, busy, 0);
      check_val({name, "_ops"}, n_ops, exp_ops);
      if (exp_ops > 0) begin
         check_val({name, "_scan_cycles"}, first_op_cyc - (s_cyc + 1), exp_scan);
         check_val({name, "_done_after_last"}, cyc - last_done_cyc, 1);
         want_lat = exp_scan + exp_ops * (LAT + 1);
      end else begin
         want_lat = (cur_mod == '0) ? 1 : NBITS;
      end
      check_val({name, "_latency"}, cyc - (s_cyc + 1), want_lat);
   endtask

   initial begin
      int  w;
      op_t o;
      rst_n     = 1'b0;
      start     = 1'b0;
      a1        = '0;
      a2        = '0;
      a3        = '0;
      mm_done   = 1'b0;
      mm_result = '0;
      repeat (3) tick();
      check_val("rst_a0", a0, 0);
      check_val("rst_done", done, 0);
      check_val("rst_err", err, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_mm_start", mm_start, 0);
      check_val("rst_mm_n", mm_n, 0);
      rst_n = 1'b1;
      tick();

      // 3^5 mod 7: MUL(1,3) SQR(3,3) SQR(2,2) MUL(4,3) -> 5
      o.a = 1; o.b = 3; op_q.push_back(o);
      o.a = 3; o.b = 3; op_q.push_back(o);
      o.a = 2; o.b = 2; op_q.push_back(o);
      o.a = 4; o.b = 3; op_q.push_back(o);
      op_chk = 1;
      start_job(3, 5, 7);
      wait_done("small", -1, 20);
      check_val("small_ops_left", op_q.size(), 0);
      op_chk = 0;

      start_job(4, 0, 7);
      wait_done("zero_exp", -1, -1);
      start_job(4, 0, 1);
      wait_done("zero_exp_mod1", -1, -1);
      start_job(5, 9, 0);
      wait_done("mod_zero", -1, -1);

      start_job(FA1, FA2, FA3);
      wait_done("full", 300, -1);
      start_job(FB1, FA2, FA3);
      wait_done("restart", -1, -1);

      // Abort a job with reset while the first square is in flight.
      start_job(FA1, FA2, FA3);
      w = 0;
      while (n_ops < 2 && w < LIMIT) begin
         tick();
         w++;
      end
      check_val("reach_sqr", n_ops, 2);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_a0", a0, 0);
      check_val("arst_done", done, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_mm_start", mm_start, 0);
      check_val("arst_mm_a", mm_a, 0);
      check_val("arst_mm_b", mm_b, 0);
      check_val("arst_mm_n", mm_n, 0);
      void'(exp_q.pop_front());
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      start_job(3, 5, 7);
      wait_done("post_reset", -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pow_sched_ctrl.md
Name: pow_sched_ctrl

Overview:
Sequencer for 256-bit modular exponentiation a0 = a1^a2 mod a3 using left-to-right square-and-multiply. It owns the operand/result registers and drives one external shared modular-multiplier unit through a start/done handshake. The block scans the exponent, skips leading zeros without multiplier traffic, and issues SQR/MUL operations. It is the control half of the Power datapath; the multiplier is instantiated alongside it.

Parameters:
NBITS, 256, operand width in bits (a1, a2, a3, a0, mm_* buses)
IDX_W, 8, width of the exponent bit index; must satisfy 2^IDX_W >= NBITS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  job request; sampled high while in IDLE or DONE
a1  input  NBITS  base; must be < a3 (not checked)
a2  input  NBITS  exponent
a3  input  NBITS  modulus
a0  output  NBITS  result, valid while done=1
done  output  1  job complete; held high until next start is accepted
err  output  1  modulus==0 error; valid with done
busy  output  1  high from start acceptance until done
mm_start  output  1  one-cycle pulse launching a multiplier op
mm_a  output  NBITS  multiplier operand A, stable from mm_start to mm_done
mm_b  output  NBITS  multiplier operand B, stable from mm_start to mm_done
mm_n  output  NBITS  modulus to multiplier (latched a3)
mm_done  input  1  one-cycle pulse: mm_result valid
mm_result  input  NBITS  (mm_a*mm_b) mod mm_n

Behaviour:
- Reset (async, any state): state=IDLE; a0=0, done=0, err=0, busy=0, mm_start=0, mm_a=mm_b=mm_n=0; internal r=0, idx=NBITS-1.
- States: IDLE, SCAN, MUL_WAIT, SQR_WAIT, DONE.
- IDLE/DONE + start=1: latch a1->base, a2->exp, a3->mod, idx=NBITS-1, r=0. Clear done/err, set busy, go to SCAN next cycle. start in any other state is ignored; latched operands do not change mid-job.
- SCAN (1 cycle per bit, no multiplier op):
  - mod==0: a0=0, err=1 -> DONE.
  - exp[idx]=0 and idx>0: idx--.
  - exp[idx]=0 and idx==0 (exponent zero): a0 = (mod==1) ? 0 : 1 -> DONE.
  - exp[idx]=1: pulse mm_start with mm_a=1, mm_b=base -> MUL_WAIT.
- MUL_WAIT on mm_done: r=mm_result. If idx==0: a0=r -> DONE. Otherwise idx--, pulse mm_start with mm_a=mm_b=r (square) -> SQR_WAIT.
- SQR_WAIT on mm_done: r=mm_result. If exp[idx]=1: pulse MUL with (r, base) -> MUL_WAIT. Else if idx==0: a0=r -> DONE. Else idx--, issue SQR -> SQR_WAIT.
- mm_start is registered and fires in the cycle after the decision. Exactly one op is outstanding at a time.
- mm_done outside the WAIT states is ignored. mm_done in the same cycle as mm_start is ignored; the multiplier latency is >=1.
- Latency after start acceptance:
  - leading-zero scan = (NBITS-1-msb) cycles;
  - each multiplier op = L+1 cycles, where L is the mm_start->mm_done latency;
  - DONE is entered on the cycle after the final mm_done.
- DONE: done=1, busy=0, a0 held until the next accepted start.
- mm_n = latched mod for the whole job.
- Op count = 1 + (msb index) squares + popcount(exp)-1 multiplies after the first.

Test Plan:
- Small exponent: a1=3, a2=5, a3=7, fake multiplier L=4 -> exactly 4 mm_start pulses in order MUL(1,3), SQR, SQR, MUL(r,3); 254 SCAN cycles before the first pulse; done=1 with a0=5, err=0.
- Zero exponent: a2=0, a3=7 -> no mm_start pulses; done after 256 SCAN cycles with a0=1. Repeat with a3=1 -> a0=0.
- Error: a3=0 -> done on the first SCAN cycle with err=1, a0=0, no mm_start.
- Full width: a1=0xD41B...2E31, a2=0x5972...228D, a3=0xE071...73E1 against a behavioural modmul -> a0 matches the golden model. Then restart with a1=0xC60B...B71A while in DONE -> new correct result, with done dropping the cycle after acceptance.
- Robustness: start pulsed mid-job -> ignored, operands unchanged. Spurious mm_done while in SCAN -> ignored. rst_n low during SQR_WAIT -> all outputs 0 immediately; the next start runs cleanly to completion.
